// File: rtl/cache_refill_ctrl.sv
// Single-outstanding cache refill controller: accepts one miss, picks a victim way,
// fetches the block from memory and writes it into the addressed set for one cycle.
module cache_refill_ctrl #(
  parameter int TAG_W    = 24,
  parameter int SET_BITS = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      miss_valid,
  output logic                      miss_ready,
  input  logic [TAG_W-1:0]          miss_tag,
  input  logic [SET_BITS-1:0]       miss_set,
  input  logic [7:0]                way_valid,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [TAG_W+SET_BITS-1:0] mem_req_addr,
  input  logic                      mem_rsp_valid,
  input  logic [255:0]              mem_rsp_data,
  output logic [SET_BITS-1:0]       wr_set,
  output logic [7:0]                regWrite,
  output logic [7:0]                decOut1b,
  output logic [7:0]                inp_viv,
  output logic [TAG_W-1:0]          in_tag,
  output logic [255:0]              inputData,
  output logic                      done,
  output logic [2:0]                done_way,
  output logic                      busy,
  output logic [2:0]                fsm_state
);

  // Handshakes: a miss transfers on a rising edge where miss_valid && miss_ready;
  // the memory request transfers where mem_req_valid && mem_req_ready, and
  // mem_req_valid/mem_req_addr stay stable until then. The response has no ready
  // and is only consumed in S_WAIT.

  localparam int NUM_SETS = 1 << SET_BITS;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_FILL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state;
  logic [2:0]          rr_ptr [NUM_SETS];
  logic [TAG_W-1:0]    lat_tag;
  logic [SET_BITS-1:0] lat_set;
  logic [2:0]          victim;
  logic                victim_from_ptr;

  logic [2:0] first_free;
  logic       any_free;
  logic [2:0] victim_sel;

  // Lowest-index invalid way wins; round-robin only when the set is full.
  always_comb begin
    first_free = 3'd0;
    any_free   = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!way_valid[i]) begin
        first_free = 3'(i);
        any_free   = 1'b1;
      end
    end
    victim_sel = any_free ? first_free : rr_ptr[miss_set];
  end

  assign decOut1b  = regWrite;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      miss_ready      <= 1'b1;
      busy            <= 1'b0;
      mem_req_valid   <= 1'b0;
      mem_req_addr    <= '0;
      regWrite        <= 8'h00;
      inp_viv         <= 8'h00;
      in_tag          <= '0;
      wr_set          <= '0;
      inputData       <= '0;
      done            <= 1'b0;
      done_way        <= 3'd0;
      lat_tag         <= '0;
      lat_set         <= '0;
      victim          <= 3'd0;
      victim_from_ptr <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) rr_ptr[s] <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (miss_valid) begin
            lat_tag         <= miss_tag;
            lat_set         <= miss_set;
            victim          <= victim_sel;
            victim_from_ptr <= !any_free;
            mem_req_addr    <= {miss_tag, miss_set};
            mem_req_valid   <= 1'b1;
            miss_ready      <= 1'b0;
            busy            <= 1'b1;
            state           <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            inputData <= mem_rsp_data;
            regWrite  <= 8'b1 << victim;
            inp_viv   <= 8'b1 << victim;
            in_tag    <= lat_tag;
            wr_set    <= lat_set;
            state     <= S_FILL;
          end
        end
        S_FILL: begin
          regWrite <= 8'h00;
          inp_viv  <= 8'h00;
          if (victim_from_ptr) rr_ptr[lat_set] <= rr_ptr[lat_set] + 3'd1;
          done     <= 1'b1;
          done_way <= victim;
          state    <= S_DONE;
        end
        S_DONE: begin
          done       <= 1'b0;
          busy       <= 1'b0;
          miss_ready <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          state         <= S_IDLE;
          miss_ready    <= 1'b1;
          busy          <= 1'b0;
          mem_req_valid <= 1'b0;
          regWrite      <= 8'h00;
          inp_viv       <= 8'h00;
          done          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: hand-computed victims, latency and reset-abort cases.
module tb_cache_refill_ctrl;

  localparam int TAG_W    = 24;
  localparam int SET_BITS = 3;
  localparam int AW       = TAG_W + SET_BITS;

  logic                clk = 1'b0;
  logic                reset;
  logic                miss_valid;
  logic                miss_ready;
  logic [TAG_W-1:0]    miss_tag;
  logic [SET_BITS-1:0] miss_set;
  logic [7:0]          way_valid;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic [AW-1:0]       mem_req_addr;
  logic                mem_rsp_valid;
  logic [255:0]        mem_rsp_data;
  logic [SET_BITS-1:0] wr_set;
  logic [7:0]          regWrite;
  logic [7:0]          decOut1b;
  logic [7:0]          inp_viv;
  logic [TAG_W-1:0]    in_tag;
  logic [255:0]        inputData;
  logic                done;
  logic [2:0]          done_way;
  logic                busy;
  logic [2:0]          fsm_state;

  int checks = 0;
  int errors = 0;

  cache_refill_ctrl #(.TAG_W(TAG_W), .SET_BITS(SET_BITS)) dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_tag(miss_tag), .miss_set(miss_set), .way_valid(way_valid),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .wr_set(wr_set), .regWrite(regWrite), .decOut1b(decOut1b),
    .inp_viv(inp_viv), .in_tag(in_tag), .inputData(inputData),
    .done(done), .done_way(done_way), .busy(busy), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle outputs before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_refill(input logic [TAG_W-1:0] tag, input logic [SET_BITS-1:0] set,
                           input logic [7:0] wv, input logic [2:0] exp_way,
                           input int ready_delay, input logic rsp_in_req);
    logic [255:0] data;
    logic [255:0] junk;
    logic [AW-1:0] exp_addr;
    logic [7:0] oh;
    data     = {8{$urandom()}};
    junk     = ~data;
    exp_addr = {tag, set};
    oh       = 8'b1 << exp_way;
    check("idle_miss_ready", miss_ready, 1'b1);
    miss_valid = 1'b1; miss_tag = tag; miss_set = set; way_valid = wv;
    step();
    miss_valid = 1'b0; way_valid = $urandom_range(0, 255);
    check("req_valid", mem_req_valid, 1'b1);
    check("req_addr", mem_req_addr, exp_addr);
    check("req_busy", busy, 1'b1);
    check("req_miss_ready", miss_ready, 1'b0);
    for (int d = 0; d < ready_delay; d++) begin
      if (rsp_in_req && d == 0) begin
        mem_rsp_valid = 1'b1; mem_rsp_data = junk;
      end
      step();
      mem_rsp_valid = 1'b0;
      check("stall_valid", mem_req_valid, 1'b1);
      check("stall_addr", mem_req_addr, exp_addr);
      check("stall_no_write", regWrite, 8'h00);
      check("stall_no_done", done, 1'b0);
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("wait_req_dropped", mem_req_valid, 1'b0);
    check("wait_no_write", regWrite, 8'h00);
    mem_rsp_valid = 1'b1; mem_rsp_data = data;
    step();
    mem_rsp_valid = 1'b0; mem_rsp_data = junk;
    check("fill_regWrite", regWrite, oh);
    check("fill_decOut1b", decOut1b, oh);
    check("fill_inp_viv", inp_viv, oh);
    check("fill_in_tag", in_tag, tag);
    check("fill_wr_set", wr_set, set);
    check("fill_data", inputData, data);
    check("fill_no_done", done, 1'b0);
    step();
    check("done_pulse", done, 1'b1);
    check("done_way", done_way, exp_way);
    check("done_no_write", regWrite, 8'h00);
    check("done_data_hold", inputData, data);
    check("done_tag_hold", in_tag, tag);
    step();
    check("back_idle_ready", miss_ready, 1'b1);
    check("back_idle_busy", busy, 1'b0);
    check("back_idle_done", done, 1'b0);
  endtask

  initial begin
    reset = 1'b1; miss_valid = 1'b0; miss_tag = '0; miss_set = '0; way_valid = 8'h00;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    step();
    step();
    reset = 1'b0;
    check("rst_miss_ready", miss_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_req_addr", mem_req_addr, '0);
    check("rst_regWrite", regWrite, 8'h00);
    check("rst_inp_viv", inp_viv, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_done_way", done_way, 3'd0);
    check("rst_in_tag", in_tag, '0);
    check("rst_wr_set", wr_set, '0);
    check("rst_data", inputData, '0);

    // Basic refill with known address value.
    miss_valid = 1'b1; miss_tag = 24'hABCDEF; miss_set = 3'd3; way_valid = 8'h00;
    step();
    miss_valid = 1'b0;
    check("vec_addr_const", mem_req_addr, 27'h55E6F7B);
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 256'h1234; step(); mem_rsp_valid = 1'b0;
    check("vec_regWrite", regWrite, 8'h01);
    check("vec_inp_viv", inp_viv, 8'h01);
    check("vec_in_tag", in_tag, 24'hABCDEF);
    check("vec_wr_set", wr_set, 3'd3);
    step();
    check("vec_done", done, 1'b1);
    check("vec_done_way", done_way, 3'd0);
    step();

    // First invalid way chosen; pointer of set 1 must stay at 0.
    do_refill(24'h000111, 3'd1, 8'hEF, 3'd4, 0, 1'b0);
    do_refill(24'h000222, 3'd1, 8'hFF, 3'd0, 0, 1'b0);
    do_refill(24'h000333, 3'd6, 8'h07, 3'd3, 1, 1'b0);

    // Round robin through a full set, wrapping after way 7.
    for (int k = 0; k < 9; k++)
      do_refill(24'h500000 + 24'(k), 3'd5, 8'hFF, 3'(k % 8), 0, 1'b0);
    do_refill(24'h200000, 3'd2, 8'hFF, 3'd0, 0, 1'b0);

    // Backpressured request with a stray response while in REQ.
    do_refill(24'hC0FFEE, 3'd7, 8'h3F, 3'd6, 5, 1'b1);

    // Reset in WAIT aborts the refill and clears round-robin state.
    miss_valid = 1'b1; miss_tag = 24'hDEAD00; miss_set = 3'd5; way_valid = 8'hFF;
    step();
    miss_tag = 24'hBEEF00; miss_set = 3'd4; way_valid = 8'h00;
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    step();
    check("busy_miss_ignored_busy", busy, 1'b1);
    check("busy_miss_ignored_req", mem_req_valid, 1'b0);
    check("busy_miss_ignored_ready", miss_ready, 1'b0);
    miss_valid = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    check("abort_miss_ready", miss_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_regWrite", regWrite, 8'h00);
    mem_rsp_valid = 1'b1; mem_rsp_data = {8{32'hFFFF0000}}; step(); mem_rsp_valid = 1'b0;
    check("late_rsp_no_write", regWrite, 8'h00);
    check("late_rsp_data", inputData, '0);
    check("late_rsp_busy", busy, 1'b0);
    step();
    check("late_rsp_no_done", done, 1'b0);
    do_refill(24'hABC000, 3'd5, 8'hFF, 3'd0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
